// File: rtl/pkt_capture.sv
// pkt_capture: Avalon-ST frame ingress. Pushes frame words into the shared
// data FIFO, truncates oversize frames, allocates a host ring slot per packet
// and hands the packet descriptor to the burst write controller.
module pkt_capture #(
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE      = 32'h0001_0000,
  parameter int          MAX_PKT_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic        st_ready,
  output logic [31:0] fifo_in,
  output logic        wr_to_fifo,
  input  logic        full,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] write_address,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CAPTURE   = 3'd1;
  localparam logic [2:0] S_TRUNC     = 3'd2;
  localparam logic [2:0] S_DISCARD   = 3'd3;
  localparam logic [2:0] S_HANDOFF   = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  localparam logic [31:0] RING_END = BUF_BASE + BUF_SIZE;
  localparam logic [15:0] MAX_W    = 16'(MAX_PKT_WORDS);

  logic [2:0]  state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] pkt_end_q, pkt_end_d;
  logic        wr_ctrl_q, wr_ctrl_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  logic        accept;
  logic        go_hand;
  logic [31:0] nbytes;
  logic [31:0] ptr_adv;

  // Backpressure: pushing states follow FIFO full, draining states always
  // accept, handoff/wait hold the next frame off.
  always_comb begin
    st_ready = 1'b0;
    case (state_q)
      S_IDLE:             st_ready = enable ? !full : 1'b1;
      S_CAPTURE:          st_ready = !full;
      S_TRUNC, S_DISCARD: st_ready = 1'b1;
      default:            st_ready = 1'b0;
    endcase
  end

  assign accept     = st_valid && st_ready;
  assign wr_to_fifo = accept && ((state_q == S_IDLE && st_sop && enable) ||
                                 state_q == S_CAPTURE);
  assign fifo_in    = st_data;

  assign wr_ctrl       = wr_ctrl_q;
  assign pkt_begin     = 32'd0;
  assign pkt_end       = pkt_end_q;
  assign write_address = waddr_q;
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;

  // Frame FSM, slot allocation and statistics. The descriptor is latched on
  // the eop-accept edge so it is already valid while wr_ctrl is high.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    ptr_d        = ptr_q;
    waddr_d      = waddr_q;
    pkt_end_d    = pkt_end_q;
    wr_ctrl_d    = 1'b0;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    go_hand      = 1'b0;
    nbytes       = 32'd0;
    ptr_adv      = waddr_q + pkt_end_q;
    case (state_q)
      S_IDLE: begin
        if (accept && st_sop) begin
          if (enable) begin
            word_cnt_d = 16'd1;
            if (st_eop) go_hand = 1'b1;
            else        state_d = S_CAPTURE;
          end else begin
            drop_count_d = drop_count_q + 32'd1;
            if (!st_eop) state_d = S_DISCARD;
          end
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (st_eop)                   go_hand = 1'b1;
          else if (word_cnt_d == MAX_W) state_d = S_TRUNC;
        end
      end
      S_TRUNC: begin
        if (accept && st_eop) go_hand = 1'b1;
      end
      S_DISCARD: begin
        if (accept && st_eop) state_d = S_IDLE;
      end
      S_HANDOFF: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wr_ctrl_rdy) begin
          ptr_d       = (ptr_adv == RING_END) ? BUF_BASE : ptr_adv;
          pkt_count_d = pkt_count_q + 32'd1;
          word_cnt_d  = 16'd0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_hand) begin
      // Never let a packet straddle the ring end: restart at the base.
      nbytes    = {14'd0, word_cnt_d, 2'b00};
      state_d   = S_HANDOFF;
      wr_ctrl_d = 1'b1;
      pkt_end_d = nbytes;
      waddr_d   = (ptr_q + nbytes > RING_END) ? BUF_BASE : ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= 16'd0;
      ptr_q        <= BUF_BASE;
      waddr_q      <= BUF_BASE;
      pkt_end_q    <= 32'd0;
      wr_ctrl_q    <= 1'b0;
      pkt_count_q  <= 32'd0;
      drop_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      ptr_q        <= ptr_d;
      waddr_q      <= waddr_d;
      pkt_end_q    <= pkt_end_d;
      wr_ctrl_q    <= wr_ctrl_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_pkt_capture.sv
// tb_pkt_capture: randomized frames against a queue-based packet model.
// The driver pushes expected FIFO words and descriptors; a monitor pops and
// compares whenever the DUT pushes or pulses wr_ctrl.
module tb_pkt_capture;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SIZE = 32'd96;
  localparam int          MAXW = 8;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [31:0] st_data = '0;
  logic        st_valid = 1'b0, st_sop = 1'b0, st_eop = 1'b0, st_ready;
  logic [31:0] fifo_in;
  logic        wr_to_fifo, full = 1'b0, wr_ctrl, wr_ctrl_rdy = 1'b0;
  logic [31:0] pkt_begin, pkt_end, write_address, pkt_count, drop_count;

  pkt_capture #(.BUF_BASE(BASE), .BUF_SIZE(SIZE), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .st_data(st_data),
    .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready),
    .fifo_in(fifo_in), .wr_to_fifo(wr_to_fifo), .full(full), .wr_ctrl(wr_ctrl),
    .wr_ctrl_rdy(wr_ctrl_rdy), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .write_address(write_address), .pkt_count(pkt_count), .drop_count(drop_count));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] nbytes; int cyc; } hand_t;
  logic [31:0] exp_push[$];
  hand_t       exp_hand[$];
  int tests = 0, fails = 0, cyc = 0, phase = 0;
  int m_pkts = 0, m_drops = 0;
  logic [31:0] m_off = 0;
  logic [31:0] hold_addr, hold_end;
  bit full_en = 0, rdy_en = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO full noise
  always @(posedge clk) begin
    #1;
    full = full_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // Write controller model: random spurious rdy during the wr_ctrl cycle,
  // then a done pulse after a random delay.
  always @(posedge clk) begin
    #1;
    if (wr_ctrl === 1'b1 && rdy_en) begin
      wr_ctrl_rdy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      wr_ctrl_rdy = 1'b0;
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      wr_ctrl_rdy = 1'b1;
      @(posedge clk); #1;
      wr_ctrl_rdy = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    hand_t h;
    if (reset) phase = 0;
    else begin
      if (wr_to_fifo) begin
        check("push_while_full", {31'd0, full}, 32'd0);
        if (exp_push.size() == 0) check("unexpected_push", 32'd1, 32'd0);
        else check("push_data", fifo_in, exp_push.pop_front());
      end
      if (phase != 0) check("stall_ready", {31'd0, st_ready}, 32'd0);
      if (wr_ctrl) begin
        if (phase == 1) check("wr_ctrl_width", 32'd2, 32'd1);
        if (exp_hand.size() == 0) check("unexpected_wr_ctrl", 32'd1, 32'd0);
        else begin
          h = exp_hand.pop_front();
          check("write_address", write_address, h.addr);
          check("pkt_end", pkt_end, h.nbytes);
          check("pkt_begin", pkt_begin, 32'd0);
          check("handoff_latency", cyc, h.cyc);
        end
        hold_addr = write_address;
        hold_end  = pkt_end;
        phase = 1;
      end else if (phase == 1) phase = 2;
      if (phase == 2) begin
        check("hold_addr", write_address, hold_addr);
        check("hold_end", pkt_end, hold_end);
        if (wr_ctrl_rdy) phase = 0;
      end
    end
  end

  // Present one word until accepted; returns the cycle of acceptance.
  task automatic put_word(input logic [31:0] d, input bit sop, input bit eop,
                          output bit ok, output int acc_cyc);
    bit acc;
    ok = 0;
    acc_cyc = 0;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        st_valid = 0; @(posedge clk); #1;
        continue;
      end
      st_valid = 1; st_data = d; st_sop = sop; st_eop = eop;
      @(negedge clk);
      acc = st_ready;
      acc_cyc = cyc;
      @(posedge clk); #1;
      if (acc) begin
        st_valid = 0; st_sop = 0; st_eop = 0;
        ok = 1;
        return;
      end
    end
    st_valid = 0;
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int len, input bit en);
    bit ok;
    int c;
    logic [31:0] d, nb, off;
    hand_t h;
    enable = en;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      if (en && i < MAXW) exp_push.push_back(d);
      put_word(d, i == 0, i == len - 1, ok, c);
      if (!ok) return;
      if (i == 0 && en && len > 2 && $urandom_range(0, 3) == 0) enable = 0;
      if (i == len - 1 && en) begin
        nb  = 32'((len < MAXW ? len : MAXW) * 4);
        off = (m_off + nb > SIZE) ? 32'd0 : m_off;
        h.addr = BASE + off; h.nbytes = nb; h.cyc = c + 1;
        exp_hand.push_back(h);
        m_off = (off + nb) % SIZE;
        m_pkts++;
      end
    end
    if (!en) m_drops++;
  endtask

  task automatic stray_word();
    bit ok;
    int c;
    put_word($urandom, 0, 0, ok, c);
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 1000; t++) begin
      if (exp_hand.size() == 0 && exp_push.size() == 0 && phase == 0) break;
      @(posedge clk); #1;
    end
    if (t == 1000) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
    check("rst_pkt_end", pkt_end, 32'd0);
    check("rst_waddr", write_address, BASE);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_drop_count", drop_count, 32'd0);
    check("rst_st_ready", {31'd0, st_ready}, 32'd1);
    reset = 0;

    send_frame(8, 1);
    drain();
    check("pkt_count_1", pkt_count, 32'd1);
    send_frame(4, 1);
    send_frame(4, 1);
    full_en = 1;
    send_frame(6, 1);
    send_frame(10, 1);
    send_frame(3, 0);
    send_frame(1, 1);
    stray_word();
    drain();
    check("drop_count_1", drop_count, 32'd1);
    check("pkt_count_dir", pkt_count, m_pkts);

    for (int n = 0; n < 40; n++) begin
      full_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) stray_word();
      send_frame($urandom_range(1, 14), $urandom_range(0, 9) != 0);
    end
    drain();
    check("pkt_count_final", pkt_count, m_pkts);
    check("drop_count_final", drop_count, m_drops);

    // Reset while waiting for the write controller
    full_en = 0;
    rdy_en = 0;
    send_frame(2, 1);
    for (int t = 0; t < 200 && phase != 2; t++) begin @(posedge clk); #1; end
    check("reached_wait", phase, 2);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    check("mid_rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
    check("mid_rst_pkt_end", pkt_end, 32'd0);
    check("mid_rst_waddr", write_address, BASE);
    check("mid_rst_pkt_count", pkt_count, 32'd0);
    check("mid_rst_drop_count", drop_count, 32'd0);
    check("mid_rst_st_ready", {31'd0, st_ready}, 32'd1);
    reset = 0;
    rdy_en = 1;
    m_off = 0; m_pkts = 0; m_drops = 0;
    send_frame(1, 1);
    drain();
    check("post_rst_pkt_count", pkt_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pkt_capture.md
Name: pkt_capture

Overview:
- Ingress stage directly upstream of the burst write controller.
- Accepts captured Ethernet frames as a 32-bit Avalon-ST stream and pushes the words into the shared data FIFO.
- Once a frame is fully queued, it presents pkt_begin, pkt_end and write_address, then pulses wr_ctrl.
- Allocates host-memory slots from a ring buffer and keeps packet and drop statistics.

Parameters:
BUF_BASE, 32'h0000_0000, byte base address of the capture ring in host memory (4-byte aligned)
BUF_SIZE, 32'h0001_0000, ring size in bytes (multiple of 4, >= MAX_PKT_WORDS*4)
MAX_PKT_WORDS, 512, maximum words per handed-off packet; longer frames are truncated

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  capture enable (control register bit 0)
st_data  in  32  stream data word
st_valid  in  1  stream word valid
st_sop  in  1  first word of frame
st_eop  in  1  last word of frame
st_ready  out  1  stream backpressure (combinational)
fifo_in  out  32  data to FIFO, equal to st_data
wr_to_fifo  out  1  FIFO push strobe (combinational)
full  in  1  FIFO full
wr_ctrl  out  1  one-cycle start pulse to the write controller
wr_ctrl_rdy  in  1  write controller finished the current packet
pkt_begin  out  32  packet start byte offset (always 0)
pkt_end  out  32  packet length in bytes (word count * 4)
write_address  out  32  host byte address of the packet slot
pkt_count  out  32  packets handed off (wraps at 2^32)
drop_count  out  32  frames discarded (wraps at 2^32)

Behaviour:
- Reset: state IDLE; wr_ctrl, pkt_begin, pkt_end, pkt_count, drop_count = 0; write_address = ptr = BUF_BASE; word_cnt = 0. Reset mid-frame abandons the frame; the FIFO shares the same reset.
- accept = st_valid && st_ready. Push condition: wr_to_fifo = accept && (state is IDLE with st_sop && enable, or state is CAPTURE). fifo_in = st_data always.
- States: IDLE, CAPTURE, TRUNC, DISCARD, HANDOFF, WAIT_DONE.
- IDLE:
  - st_ready = !full when enable=1, else 1.
  - enable=1, accepted sop: push, word_cnt=1; go to HANDOFF if eop, else CAPTURE.
  - enable=0, accepted sop: drop_count++; go to DISCARD unless eop.
  - Accepted non-sop words are discarded without a push.
- CAPTURE: st_ready = !full. Each accept pushes and does word_cnt++.
  - Accepted eop: go to HANDOFF.
  - Accept that makes word_cnt == MAX_PKT_WORDS without eop: go to TRUNC.
  - st_sop inside CAPTURE is treated as data. enable falling mid-frame does not abort the frame.
- TRUNC: st_ready=1, no push; consume words until an accepted eop, then go to HANDOFF.
- DISCARD: st_ready=1, no push; on accepted eop go to IDLE.
- HANDOFF (one cycle): st_ready=0.
  - If ptr + word_cnt*4 > BUF_BASE + BUF_SIZE, set slot = BUF_BASE, else slot = ptr. A packet never straddles the ring end.
  - Register write_address = slot, pkt_begin = 0, pkt_end = word_cnt*4. wr_ctrl = 1 for exactly this cycle. Go to WAIT_DONE.
- Handoff latency: wr_ctrl is high in the cycle right after the eop-accept cycle.
- WAIT_DONE: st_ready=0, so the frame that follows is held off. pkt_begin, pkt_end and write_address are held stable.
  - On wr_ctrl_rdy=1: ptr = write_address + pkt_end; if ptr equals BUF_BASE + BUF_SIZE, set ptr = BUF_BASE.
  - Same cycle: pkt_count++, word_cnt=0, go to IDLE.
  - wr_ctrl_rdy outside WAIT_DONE is ignored.
- Arithmetic: all address math is 32-bit unsigned. word_cnt is 16 bits. pkt_end never exceeds MAX_PKT_WORDS*4.
- full=1 in any pushing state holds st_ready low; no word is lost or duplicated.
- sop && eop on one word gives a 1-word packet: pkt_end = 4.

Test Plan:
- Reset, enable=1, one 8-word frame with no backpressure -> 8 pushes of the exact data; next cycle wr_ctrl=1 for one cycle, pkt_end=32, write_address=BUF_BASE; after wr_ctrl_rdy, pkt_count=1.
- Two back-to-back 4-word frames -> second frame stalled (st_ready=0) until wr_ctrl_rdy; second write_address = BUF_BASE+16.
- full toggled every other cycle during a 6-word frame -> exactly 6 pushes in order, pkt_end=24.
- BUF_SIZE=64, frames of 12 words then 8 words -> first slot 0, second slot wraps to BUF_BASE (48+32 > 64); ptr then 32.
- MAX_PKT_WORDS=4, 10-word frame -> 4 pushes, pkt_end=16, remaining 6 words consumed without push.
- enable=0, 3-word frame, then enable=1 and a 1-word sop&eop frame -> drop_count=1, no pushes for the first frame; second frame pkt_end=4; reset asserted in WAIT_DONE returns all outputs to 0 and write_address to BUF_BASE.
